plot_arbiter: RTL and testbench

Shares the single pixel-write port of the `vga_adapter` among several drawing clients: board setup, snake head/tail, food and wrong-food. Each client raises a request holding one pixel (x, y, colour); the arbiter grants one per cycle round-robin and registers it onto `x_out`/`y_out`/`colour`/`plot`. An optional raster-clear engine takes the port exclusively to fill the whole screen with one colour. The arbiter sits between the game datapath and `vga_adapter`.

---
 rtl/plot_arbiter.sv | 151 +++++++++++++++
 tb/tb_plot_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/plot_arbiter.sv
// Round-robin arbiter sharing the vga_adapter pixel-write port among NREQ drawing clients.
// Optional raster-clear engine is compiled in when PLOT_ARB_CLEAR_EN is defined.
module plot_arbiter #(
  parameter int             NREQ         = 4,
  parameter int             XW           = 8,
  parameter int             YW           = 7,
  parameter int             CW           = 3,
  parameter int             XMAX         = 159,
  parameter int             YMAX         = 119,
  parameter logic [CW-1:0]  CLEAR_COLOUR = '0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*XW-1:0]   req_x,
  input  logic [NREQ*YW-1:0]   req_y,
  input  logic [NREQ*CW-1:0]   req_colour,
  output logic [NREQ-1:0]      gnt,
  input  logic                 clear_start,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic [XW-1:0]        x_out,
  output logic [YW-1:0]        y_out,
  output logic [CW-1:0]        colour,
  output logic                 plot
);
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          r_state, w_state_nxt;
  logic [LW-1:0]   r_last;
  logic [LW-1:0]   w_win;
  logic            w_any;
  logic            w_fire;
  logic            w_clr_go;
  logic            w_clr_last;
  logic [XW-1:0]   w_cx;
  logic [YW-1:0]   w_cy;
  int              w_j;

  logic [XW-1:0]   w_x   [NREQ];
  logic [YW-1:0]   w_y   [NREQ];
  logic [CW-1:0]   w_col [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign w_x[k]   = req_x[k*XW +: XW];
    assign w_y[k]   = req_y[k*YW +: YW];
    assign w_col[k] = req_colour[k*CW +: CW];
  end

  // Walk from farthest to nearest so the client closest after r_last wins.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_j   = 0;
    for (int i = NREQ; i >= 1; i--) begin
      w_j = (int'(r_last) + i) % NREQ;
      if (req[LW'(w_j)]) begin
        w_win = LW'(w_j);
        w_any = 1'b1;
      end
    end
  end

  // A clear request pre-empts any grant in the cycle it arrives.
  assign w_fire = w_any && (r_state == S_IDLE) && !w_clr_go;
  assign gnt    = w_fire ? (NREQ'(1) << w_win) : '0;

`ifdef PLOT_ARB_CLEAR_EN
  logic [XW-1:0] r_cx;
  logic [YW-1:0] r_cy;
  logic          r_done;

  assign w_clr_go   = clear_start && (r_state == S_IDLE);
  assign w_clr_last = (r_state == S_CLEAR) && (r_cx == XW'(XMAX)) && (r_cy == YW'(YMAX));
  assign w_cx       = r_cx;
  assign w_cy       = r_cy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cx   <= '0;
      r_cy   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_clr_last;
      if (w_clr_go) begin
        r_cx <= '0;
        r_cy <= '0;
      end else if (r_state == S_CLEAR) begin
        if (r_cx == XW'(XMAX)) begin
          r_cx <= '0;
          r_cy <= (r_cy == YW'(YMAX)) ? '0 : r_cy + 1'b1;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end
    end
  end

  assign clear_busy = (r_state == S_CLEAR);
  assign clear_done = r_done;
`else
  logic w_unused;
  assign w_unused   = clear_start | (XMAX == 0) | (YMAX == 0) | (|CLEAR_COLOUR);
  assign w_clr_go   = 1'b0;
  assign w_clr_last = 1'b0;
  assign w_cx       = '0;
  assign w_cy       = '0;
  assign clear_busy = 1'b0;
  assign clear_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_clr_go)   w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_clr_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_out  <= '0;
      y_out  <= '0;
      colour <= '0;
      plot   <= 1'b0;
      r_last <= LW'(NREQ - 1);
    end else if (r_state == S_CLEAR) begin
      x_out  <= w_cx;
      y_out  <= w_cy;
      colour <= CLEAR_COLOUR;
      plot   <= 1'b1;
    end else if (w_fire) begin
      x_out  <= w_x[w_win];
      y_out  <= w_y[w_win];
      colour <= w_col[w_win];
      plot   <= 1'b1;
      r_last <= w_win;
    end else begin
      plot   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed self-checking bench for plot_arbiter; clear-engine steps build only with PLOT_ARB_CLEAR_EN.
module tb_plot_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [11:0] req_colour;
  logic [3:0]  gnt;
  logic        clear_start;
  logic        clear_busy;
  logic        clear_done;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour;
  logic        plot;

  int total = 0;
  int bad   = 0;

  plot_arbiter dut (
    .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .gnt(gnt), .clear_start(clear_start),
    .clear_busy(clear_busy), .clear_done(clear_done), .x_out(x_out),
    .y_out(y_out), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req = '0;
    clear_start = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic set_client(input int k, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    req_x[k*8 +: 8]      = x;
    req_y[k*7 +: 7]      = y;
    req_colour[k*3 +: 3] = c;
  endtask

  initial begin
    req_x = '0; req_y = '0; req_colour = '0;
    resetn = 1'b0; req = '0; clear_start = 1'b0;
    #2;
    chk("rst_x", 32'(x_out), 0);
    chk("rst_y", 32'(y_out), 0);
    chk("rst_col", 32'(colour), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_busy", 32'(clear_busy), 0);
    chk("rst_done", 32'(clear_done), 0);
    do_reset();

    // single client 2 grant, then drop
    set_client(2, 8'd60, 7'd40, 3'b010);
    req = 4'b0100;
    #1 chk("t1_gnt", 32'(gnt), 32'b0100);
    tick();
    req = 4'b0000;
    chk("t1_plot", 32'(plot), 1);
    chk("t1_x", 32'(x_out), 60);
    chk("t1_y", 32'(y_out), 40);
    chk("t1_col", 32'(colour), 3'b010);
    tick();
    chk("t1_plot_off", 32'(plot), 0);
    chk("t1_x_hold", 32'(x_out), 60);
    chk("t1_col_hold", 32'(colour), 3'b010);

    // all clients requesting from reset: 0,1,2,3,0,1,2,3
    do_reset();
    for (int k = 0; k < 4; k++) set_client(k, 8'(10 + k), 7'(20 + k), 3'(k));
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1 chk("t2_gnt", 32'(gnt), 32'(1) << (i % 4));
      tick();
      chk("t2_plot", 32'(plot), 1);
      chk("t2_x", 32'(x_out), 32'(10 + i % 4));
      chk("t2_col", 32'(colour), 32'(i % 4));
    end

    // last=1 with clients 0 and 3 pending: 3 before 0
    req = 4'b0010;
    #1 chk("t3_gnt1", 32'(gnt), 32'b0010);
    tick();
    req = 4'b1001;
    #1 chk("t3_gnt3", 32'(gnt), 32'b1000);
    tick();
    chk("t3_x3", 32'(x_out), 13);
    chk("t3_gnt0", 32'(gnt), 32'b0001);
    tick();
    chk("t3_x0", 32'(x_out), 10);
    req = 4'b0000;
    tick();

`ifdef PLOT_ARB_CLEAR_EN
    begin
      int errs;
      errs = 0;
      clear_start = 1'b1;
      req = 4'b0010;
      #1 chk("c_gnt_start", 32'(gnt), 0);
      tick();
      clear_start = 1'b0;
      chk("c_busy", 32'(clear_busy), 1);
      chk("c_plot0", 32'(plot), 0);
      chk("c_gnt_busy", 32'(gnt), 0);
      for (int k = 0; k < 19200; k++) begin
        tick();
        if (plot !== 1'b1 || x_out !== 8'(k % 160) || y_out !== 7'(k / 160) || colour !== 3'b000) errs++;
        if (k < 19199) begin
          if (gnt !== 4'b0000 || clear_done !== 1'b0 || clear_busy !== 1'b1) errs++;
        end
      end
      chk("c_pixel_errs", 32'(errs), 0);
      chk("c_last_x", 32'(x_out), 159);
      chk("c_last_y", 32'(y_out), 119);
      chk("c_done", 32'(clear_done), 1);
      chk("c_busy_end", 32'(clear_busy), 0);
      chk("c_gnt_end", 32'(gnt), 32'b0010);
      tick();
      req = 4'b0000;
      chk("c_done_off", 32'(clear_done), 0);
      chk("c_after_x", 32'(x_out), 11);

      // reset 500 cycles into a clear
      tick();
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      for (int k = 0; k < 500; k++) tick();
      resetn = 1'b0;
      #1;
      chk("cr_x", 32'(x_out), 0);
      chk("cr_y", 32'(y_out), 0);
      chk("cr_plot", 32'(plot), 0);
      chk("cr_busy", 32'(clear_busy), 0);
      tick();
      resetn = 1'b1;
      req = 4'b0001;
      #1 chk("cr_gnt", 32'(gnt), 32'b0001);
      errs = 0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (clear_done !== 1'b0) errs++;
      end
      chk("cr_no_done", 32'(errs), 0);
      req = 4'b0000;
    end
`else
    // clear_start has no effect in this build; last=0 so client 1 is next
    clear_start = 1'b1;
    req = 4'b0010;
    #1 chk("n_gnt", 32'(gnt), 32'b0010);
    chk("n_busy", 32'(clear_busy), 0);
    chk("n_done", 32'(clear_done), 0);
    tick();
    clear_start = 1'b0;
    req = 4'b0000;
    chk("n_plot", 32'(plot), 1);
    chk("n_x", 32'(x_out), 11);
    chk("n_busy2", 32'(clear_busy), 0);
    chk("n_done2", 32'(clear_done), 0);
    tick();
    chk("n_plot_off", 32'(plot), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
